// File: rtl/if_prefetch_unit.sv
// Instruction prefetch stage: sequential fetch into a DEPTH-entry {pc, instr} queue feeding decode.
// Optional perf counters enabled with `define IF_PERF_CNT_EN.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_rvalid,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DATA_W-1:0]        id_instr,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [ADDR_W-1:0]        pc_out,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_bubble_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [ADDR_W-1:0] pc_q, req_pc_q;
  logic              inflight_q, kill_q;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [OW-1:0]     occ_q, fill;
  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [DATA_W-1:0] ins_mem [DEPTH];
  logic              push, pop;

  // Space for the in-flight response is reserved at issue time, so push never overflows.
  assign fill      = occ_q + OW'(inflight_q);
  assign imem_req  = !reset && !redirect && (fill < OW'(DEPTH));
  assign imem_addr = pc_q;
  assign pc_out    = reset ? RESET_PC : pc_q;
  assign occupancy = occ_q;

  assign push     = imem_rvalid && inflight_q && !kill_q && !redirect && !reset;
  assign id_valid = !reset && !redirect && (occ_q != '0);
  assign pop      = id_valid && id_ready;
  assign id_instr = ins_mem[rd_ptr];
  assign id_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ_q      <= '0;
    end else begin
      inflight_q <= imem_req;
      kill_q     <= redirect && inflight_q;
      if (imem_req) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + ADDR_W'(PC_STEP);
      end
      if (redirect) begin
        pc_q   <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ_q  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   occ_q <= occ_q + 1'b1;
          2'b01:   occ_q <= occ_q - 1'b1;
          default: occ_q <= occ_q;
        endcase
      end
    end
  end

  // Queue storage needs no reset; occupancy alone qualifies the entries.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= req_pc_q;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (imem_req)              perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (id_ready && !id_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomised + directed bench for if_prefetch_unit against a queue-based reference model.
module tb_if_prefetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A50000;

  logic        clk = 1'b0;
  logic        reset, redirect, id_ready, inject;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_rvalid = 1'b0, id_valid;
  logic [31:0] imem_addr, imem_rdata = '0, id_instr, id_pc, pc_out;
  logic [2:0]  occupancy;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  if_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .pc_out(pc_out), .occupancy(occupancy)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  // 1-cycle memory; inject forces a spurious response for the stale-rvalid case
  always @(posedge clk) begin
    imem_rvalid <= imem_req | inject;
    imem_rdata  <= imem_addr ^ K;
  end

  int          n_chk = 0, n_err = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_pc = 0, m_inf_pc = 0, m_fetch = 0, m_bub = 0;
  bit          m_inf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance the model.
  task automatic step();
    bit e_req, e_vld;
    #1;
    e_vld = !reset && !redirect && (m_q.size() != 0);
    e_req = !reset && !redirect && (m_q.size() + int'(m_inf) < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, e_vld});
    if (e_vld) begin
      chk("id_pc", id_pc, m_q[0]);
      chk("id_instr", id_instr, m_q[0] ^ K);
    end
    chk("pc_out", pc_out, reset ? 32'h0 : m_pc);
    if (!reset) begin
      chk("occupancy", {29'b0, occupancy}, m_q.size());
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_bubble", perf_bubble_cnt, m_bub);
`endif
    end
    if (reset) begin
      m_q.delete(); m_inf = 0; m_pc = 0; m_fetch = 0; m_bub = 0;
    end else begin
      if (e_req) m_fetch++;
      if (id_ready && !e_vld) m_bub++;
      if (e_vld && id_ready) void'(m_q.pop_front());
      if (redirect) begin
        m_q.delete();
        m_pc = redirect_pc;
      end else if (m_inf) m_q.push_back(m_inf_pc);
      m_inf = e_req;
      if (e_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int first;
    logic [31:0] first_pc;
    reset = 1; redirect = 0; redirect_pc = 0; id_ready = 1; inject = 0;
    @(negedge clk);
    repeat (3) step();

    // reset release, continuous stream
    reset = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      if (id_valid && first < 0) first = i;
      step();
    end
    chk("first_valid_lat", first, 2);
    repeat (10) step();

    // backpressure fills the queue
    reset = 1; step(); reset = 0; id_ready = 0;
    repeat (10) step();
    chk("occ_full", {29'b0, occupancy}, 4);
    chk("req_when_full", {31'b0, imem_req}, 0);
    id_ready = 1;
    repeat (12) step();

    // redirect with occupancy 3 and one request in flight
    reset = 1; step(); reset = 0; id_ready = 0;
    repeat (4) step();
    chk("occ_before_redir", {29'b0, occupancy}, 3);
    redirect = 1; redirect_pc = 32'h100; step();
    redirect = 0; id_ready = 1; first = -1; first_pc = 0;
    for (int i = 1; i < 7; i++) begin
      if (id_valid && first < 0) begin first = i; first_pc = id_pc; end
      step();
    end
    chk("redir_lat", first, 3);
    chk("redir_first_pc", first_pc, 32'h100);
    repeat (4) step();

    // redirect while a pop would happen
    chk("valid_before_redir", {31'b0, id_valid}, 1);
    redirect = 1; redirect_pc = 32'h200; step();
    redirect = 0;
    chk("flush_occ", {29'b0, occupancy}, 0);
    repeat (6) step();

    // address wrap-around
    redirect = 1; redirect_pc = 32'hFFFF_FFF8; step();
    redirect = 0;
    step(); step();
    chk("wrap_addr", imem_addr, 32'h0);
    repeat (6) step();

    // mid-stream reset with occupancy 2 and a stale response afterwards
    reset = 1; step(); reset = 0; id_ready = 0;
    repeat (3) step();
    chk("occ_two", {29'b0, occupancy}, 2);
    reset = 1; inject = 1; step();
    reset = 0; inject = 0;
    chk("occ_after_reset", {29'b0, occupancy}, 0);
    chk("pc_after_reset", pc_out, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt_reset", perf_fetch_cnt, 0);
    chk("bubble_cnt_reset", perf_bubble_cnt, 0);
`endif
    id_ready = 1;
    repeat (8) step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      id_ready    = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 5);
      redirect_pc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      if ($urandom_range(99) < 10) redirect_pc = 32'hFFFF_FFF0;
      reset       = ($urandom_range(199) == 0);
      inject      = 0;
      step();
    end
    reset = 0; redirect = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
